mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store execution stage directly downstream of decode; consumes LOAD/STORE ops already classified by major opcode, plus the raw funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW encodings).
- Accepts one request, checks alignment and funct3 legality, and performs a single-word access on a req/gnt/rvalid data bus.
- Returns sign/zero-extended load data, or a store completion, to writeback via valid/ready.
- Single outstanding access; no pipelining across requests.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 255, bus watchdog limit; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset: one clock; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_store  in  1  1 = store (STORE), 0 = load (LOAD).
- req_funct3  in  3  access width and signedness.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  destination register tag, echoed on the response.
- resp_valid  out  1  result available.
- resp_ready  in  1  writeback accepts the result.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_rd  out  5  echoed tag.
- resp_err  out  2  0 = ok, 1 = misaligned, 2 = illegal funct3, 3 = bus error/timeout.
- mem_req  out  1  bus request.
- mem_gnt  in  1  bus grant.
- mem_we  out  1  write enable.
- mem_be  out  4  byte enables.
- mem_addr  out  ADDR_W  word-aligned address: {req_addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  response/write acknowledge.
- mem_rdata  in  32  read word.
- mem_err  in  1  bus error; qualified by mem_rvalid.

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset: state = IDLE; all outputs and internal registers are 0, except req_ready = 1.
- Request acceptance: happens on the IDLE cycle where req_valid & req_ready. Latch store, funct3, addr[1:0], wdata and rd.
- Legal funct3 values: loads 0, 1, 2, 4, 5; stores 0, 1, 2. Anything else is illegal.
- Misaligned accesses: halfword with addr[0] = 1; word with addr[1:0] != 0.
- Error priority: illegal funct3 takes priority over misaligned.
- Error path: go IDLE -> RESP without asserting mem_req. resp_rdata = 0.
- Legal path: IDLE -> REQ.
- REQ:
  - mem_req = 1, with mem_addr, mem_we, mem_be and mem_wdata held stable until mem_gnt.
  - On mem_gnt, deassert mem_req the next cycle and go to WAIT.
  - If mem_rvalid is high in the grant cycle, ignore it (rvalid is at least 1 cycle after gnt).
- Byte-enable encoding:
  - Byte: mem_be = 4'b0001 << addr[1:0].
  - Half: mem_be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: mem_be = 4'b1111.
  - Loads drive the same byte-enable pattern.
- Store data: byte replicated ×4, halfword replicated ×2.
- WAIT: on mem_rvalid, capture the result and go to RESP.
  - mem_err = 1 gives resp_err = 3 and rdata = 0.
  - Otherwise extract lane (mem_rdata >> 8*addr[1:0]).
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through. Stores give rdata = 0.
- RESP:
  - resp_valid = 1 with rdata, rd and err held stable until resp_ready.
  - On resp_valid & resp_ready, go to IDLE. req_ready rises the following cycle; no same-cycle turnaround.
- Latency: a zero-wait bus (gnt in first REQ cycle, rvalid one cycle later) gives resp_valid 3 cycles after acceptance. Error path: resp_valid 1 cycle after acceptance.
- mem_rvalid while in IDLE, REQ or RESP is ignored.
- Asynchronous reset in any state returns to IDLE immediately and drops mem_req and resp_valid. The interconnect must drain or discard the outstanding transaction.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to REQ and increments in every REQ/WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES without completion, go to RESP with resp_err = 3, rdata = 0, and deassert mem_req.
  - A late mem_rvalid is ignored.
- Undefined: no counter; the FSM waits indefinitely in REQ/WAIT.

Test Plan:
- LB addr 0x1003, bus returns 0x80FF_0000 (lane 3 = 0x80) -> mem_be = 4'b1000, mem_addr = 0x1000, resp_rdata = 0xFFFF_FF80, err = 0. Repeat as LBU -> 0x0000_0080.
- SH addr 0x2002, wdata 0x1234_ABCD -> mem_we = 1, mem_be = 4'b1100, mem_wdata = 0xABCD_ABCD. After rvalid, resp_valid with rdata = 0, err = 0.
- LW addr 0x3001 -> no mem_req ever, resp_err = 1 one cycle after acceptance. funct3 = 3'b011 load -> resp_err = 2.
- Hold mem_gnt low 5 cycles, then gnt, then rvalid with mem_err = 1 -> mem_addr/mem_be stable throughout REQ, resp_err = 3. Holding resp_ready low 4 cycles keeps resp_valid/rdata stable and req_ready = 0.
- Assert rst_n low during WAIT -> outputs zero immediately. A subsequent stray mem_rvalid is ignored, and the next LW 0x4000 returns mem_rdata correctly.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 8, never grant -> resp_err = 3 exactly at count 8, and mem_req falls in the same transition.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store execution unit: one outstanding single-word access on a req/gnt/rvalid bus.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [4:0]        resp_rd,
  output logic [1:0]        resp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;

  logic              illegal, misaligned;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;
  logic [31:0]       lane;
  logic [31:0]       load_ext;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    illegal = req_store ? (req_funct3 > 3'd2)
                        : !(req_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'b00));
    unique case (req_funct3[1:0])
      2'd0:    begin be_new = 4'b0001 << req_addr[1:0]; wdata_new = {4{req_wdata[7:0]}};  end
      2'd1:    begin be_new = req_addr[1] ? 4'b1100 : 4'b0011; wdata_new = {2{req_wdata[15:0]}}; end
      default: begin be_new = 4'b1111; wdata_new = req_wdata; end
    endcase
  end

  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    unique case (funct3_q)
      3'd0:    load_ext = {{24{lane[7]}}, lane[7:0]};
      3'd1:    load_ext = {{16{lane[15]}}, lane[15:0]};
      3'd4:    load_ext = {24'd0, lane[7:0]};
      3'd5:    load_ext = {16'd0, lane[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    rd_d     = rd_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          rd_d     = req_rd;
          rdata_d  = 32'd0;
          if (illegal) begin
            err_d   = 2'd2;
            state_d = StResp;
          end else if (misaligned) begin
            err_d   = 2'd1;
            state_d = StResp;
          end else begin
            err_d   = 2'd0;
            we_d    = req_store;
            be_d    = be_new;
            addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            wdata_d = wdata_new;
            state_d = StReq;
`ifdef MEM_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      StReq: begin
        // rvalid in the grant cycle cannot belong to this access
        if (mem_gnt) state_d = StWait;
      end
      StWait: begin
        if (mem_rvalid) begin
          state_d = StResp;
          err_d   = mem_err ? 2'd3 : 2'd0;
          rdata_d = (mem_err || store_q) ? 32'd0 : load_ext;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef MEM_TIMEOUT_EN
    if (state_q == StReq || state_q == StWait) begin
      cnt_d = cnt_q + CNT_W'(1);
      if ((state_q == StReq || !mem_rvalid) && (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1))) begin
        state_d = StResp;
        err_d   = 2'd3;
        rdata_d = 32'd0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      off_q    <= 2'd0;
      rd_q     <= 5'd0;
      we_q     <= 1'b0;
      be_q     <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 2'd0;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign mem_req    = (state_q == StReq);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_rd    = rd_q;
  assign resp_err   = err_q;
  assign mem_we     = we_q;
  assign mem_be     = be_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table with a response scoreboard,
// plus a hand-written reset-during-WAIT sequence.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic [1:0]  resp_err;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  mem_access_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_rd    (resp_rd),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          gnt_dly;
    logic [31:0] bus_rdata;
    logic        bus_err;
    int          hold;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    logic [1:0]  err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [4:0]  rd;
  } resp_t;

  vec_t  vecs[13];
  resp_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v);
    bit    err_path;
    int    cyc;
    int    k;
    resp_t e;
    err_path = (v.err == 2'd1) || (v.err == 2'd2);
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_store  = v.store;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    req_rd     = v.rd;
    sb.push_back('{v.rdata, v.err, v.rd});
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    if (!err_path) begin
      for (k = 0; k <= v.gnt_dly; k++) begin
        check("mem_req_held", 32'(mem_req), 32'd1);
        check("mem_addr", mem_addr, {v.addr[31:2], 2'b00});
        check("mem_be", 32'(mem_be), 32'(v.be));
        check("mem_we", 32'(mem_we), 32'(v.store));
        if (v.store) check("mem_wdata", mem_wdata, v.mwdata);
        if (k == v.gnt_dly) begin
          mem_gnt    = 1'b1;
          mem_rvalid = 1'b1;          // stray rvalid in the grant cycle
          mem_rdata  = 32'h5A5A_5A5A;
        end
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        cyc++;
      end
      check("mem_req_drop", 32'(mem_req), 32'd0);
      check("resp_valid_wait", 32'(resp_valid), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = v.bus_rdata;
      mem_err    = v.bus_err;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
      cyc++;
    end else begin
      check("no_mem_req", 32'(mem_req), 32'd0);
    end
    while (!resp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("resp_latency", 32'(cyc), err_path ? 32'd1 : 32'(v.gnt_dly + 3));
    for (int h = 0; h < v.hold; h++) begin
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      check("hold_rdata", resp_rdata, v.rdata);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    check("resp_valid", 32'(resp_valid), 32'd1);
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      check("resp_rdata", resp_rdata, e.rdata);
      check("resp_err", 32'(resp_err), 32'(e.err));
      check("resp_rd", 32'(resp_rd), 32'(e.rd));
    end
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_drop", 32'(resp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          st    f3    addr          wdata         rd  gd bus_rdata     be   hold be       mwdata        rdata         err
    vecs[0]  = '{1'b0, 3'd0, 32'h0000_1003, 32'h0,        5'd1, 0, 32'h80FF_0000, 1'b0, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 2'd0};
    vecs[1]  = '{1'b0, 3'd4, 32'h0000_1003, 32'h0,        5'd2, 0, 32'h80FF_0000, 1'b0, 0, 4'b1000, 32'h0,        32'h0000_0080, 2'd0};
    vecs[2]  = '{1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 5'd3, 0, 32'h0,        1'b0, 0, 4'b1100, 32'hABCD_ABCD, 32'h0,        2'd0};
    vecs[3]  = '{1'b0, 3'd2, 32'h0000_3001, 32'h0,        5'd4, 0, 32'h0,        1'b0, 0, 4'b0000, 32'h0,        32'h0,        2'd1};
    vecs[4]  = '{1'b0, 3'd3, 32'h0000_3000, 32'h0,        5'd5, 0, 32'h0,        1'b0, 0, 4'b0000, 32'h0,        32'h0,        2'd2};
    vecs[5]  = '{1'b0, 3'd2, 32'h0000_5000, 32'h0,        5'd6, 5, 32'h1111_1111, 1'b1, 4, 4'b1111, 32'h0,        32'h0,        2'd3};
    vecs[6]  = '{1'b0, 3'd1, 32'h0000_6002, 32'h0,        5'd7, 1, 32'h8001_1234, 1'b0, 0, 4'b1100, 32'h0,        32'hFFFF_8001, 2'd0};
    vecs[7]  = '{1'b0, 3'd5, 32'h0000_6000, 32'h0,        5'd8, 0, 32'h8001_F234, 1'b0, 1, 4'b0011, 32'h0,        32'h0000_F234, 2'd0};
    vecs[8]  = '{1'b1, 3'd0, 32'h0000_7001, 32'h0000_AA55, 5'd9, 0, 32'h0,        1'b0, 0, 4'b0010, 32'h5555_5555, 32'h0,        2'd0};
    vecs[9]  = '{1'b1, 3'd2, 32'h0000_7004, 32'hDEAD_BEEF, 5'd10, 2, 32'h0,       1'b0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        2'd0};
    vecs[10] = '{1'b1, 3'd5, 32'h0000_7003, 32'h0,        5'd11, 0, 32'h0,       1'b0, 0, 4'b0000, 32'h0,        32'h0,        2'd2};
    vecs[11] = '{1'b0, 3'd1, 32'h0000_6001, 32'h0,        5'd12, 0, 32'h0,       1'b0, 0, 4'b0000, 32'h0,        32'h0,        2'd1};
    vecs[12] = '{1'b0, 3'd2, 32'h0000_4000, 32'h0,        5'd13, 0, 32'hCAFE_F00D, 1'b0, 0, 4'b1111, 32'h0,       32'hCAFE_F00D, 2'd0};

    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0;
    req_wdata = 32'd0; req_rd = 5'd0; resp_ready = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = 32'd0; mem_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) do_txn(vecs[i]);

    // Reset while an LW is waiting for rvalid
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h4000; req_rd = 5'd20;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("wait_mem_req_low", 32'(mem_req), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_mem_req", 32'(mem_req), 32'd0);
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    check("arst_mem_addr", mem_addr, 32'd0);
    check("arst_mem_be", 32'(mem_be), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("stray_resp_valid", 32'(resp_valid), 32'd0);
    check("stray_req_ready", 32'(req_ready), 32'd1);
    do_txn(vecs[12]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
